// File: rtl/la_pkg.sv
// la_pkg: shared types and constants for the logic-analyzer capture path.
// Rev 1.0
`default_nettype none

package la_pkg;

   localparam int unsigned PRESC_W      = 29;
   localparam int unsigned CHANNELS_DEF = 16;

   typedef enum logic [1:0] {
      TK_NONE    = 2'b00,
      TK_RISING  = 2'b01,
      TK_FALLING = 2'b10,
      TK_BOTH    = 2'b11
   } trig_kind_e;

   typedef enum logic [2:0] {
      CS_IDLE      = 3'd0,
      CS_FILL      = 3'd1,
      CS_WAIT_TRIG = 3'd2,
      CS_POST      = 3'd3,
      CS_DONE      = 3'd4
   } capseq_state_e;

   function automatic logic kind_hit(input logic [1:0] kind, input logic rise, input logic fall);
      return (kind[0] & rise) | (kind[1] & fall);
   endfunction

endpackage

`default_nettype wire

// File: rtl/la_prescaler.sv
// la_prescaler: sample-strobe generator; the division factor is latched on load (0 treated as 1).
// Rev 1.0
`default_nettype none

module la_prescaler
   import la_pkg::*;
#(
   parameter int unsigned W = PRESC_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run_i,
   input  logic         load_i,
   input  logic [W-1:0] pf_i,
   output logic         strobe_o
);

   logic [W-1:0] pf_q;
   logic [W-1:0] cnt_q;
   logic         at_end;

   assign at_end   = (cnt_q == (pf_q - W'(1)));
   assign strobe_o = run_i & at_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         pf_q  <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         pf_q  <= (pf_i == '0) ? W'(1) : pf_i;
         cnt_q <= '0;
      end else if (run_i) begin
         cnt_q <= at_end ? '0 : (cnt_q + W'(1));
      end
   end

endmodule

`default_nettype wire

// File: rtl/capture_sequencer.sv
// capture_sequencer: one acquisition -- prescaled sampling, per-channel edge trigger, ring-buffer writes.
// Rev 1.0. Define CAPSEQ_TIMEOUT_EN to add the forced-trigger timeout in WAIT_TRIG.
`default_nettype none

module capture_sequencer
   import la_pkg::*;
#(
   parameter int unsigned CHANNELS = CHANNELS_DEF,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned PRETRIG  = 256,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PRESC_W-1:0]         prescaling_factor,
   input  logic [2*CHANNELS-1:0]      trigger_kind,
   input  logic [CHANNELS-1:0]        probes,
   input  logic                       arm,
   input  logic                       abort,
   input  logic                       dump_ack,
   output logic                       wr_en,
   output logic [$clog2(DEPTH)-1:0]   wr_addr,
   output logic [CHANNELS-1:0]        wr_data,
   output logic                       busy,
   output logic                       capture_done,
   output logic [$clog2(DEPTH)-1:0]   trig_addr,
   output logic                       trig_forced
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [2:0] ST_IDLE = CS_IDLE;
   localparam logic [2:0] ST_FILL = CS_FILL;
   localparam logic [2:0] ST_WAIT = CS_WAIT_TRIG;
   localparam logic [2:0] ST_POST = CS_POST;
   localparam logic [2:0] ST_DONE = CS_DONE;

   localparam bit          PRE_NONE  = (PRETRIG == 0);
   localparam bit          ONE_POST  = ((DEPTH - PRETRIG) == 1);
   localparam logic [AW-1:0] PRE_LAST  = PRE_NONE ? '0 : AW'(PRETRIG - 1);
   localparam logic [AW:0]   POST_LAST = (AW+1)'(DEPTH - PRETRIG - 1);

   logic [2:0]            state_q, state_d;
   logic [2*CHANNELS-1:0] kind_q;
   logic [CHANNELS-1:0]   cur_q;
   logic                  have_prev_q;
   logic [AW-1:0]         addr_q;
   logic [AW-1:0]         fill_cnt_q;
   logic [AW:0]           post_cnt_q;
   logic                  wr_en_q;
   logic [AW-1:0]         wr_addr_q;
   logic [CHANNELS-1:0]   wr_data_q;
   logic [AW-1:0]         trig_addr_q;

   logic                  arm_go, run, strobe, take;
   logic                  free_run, edge_trig, force_trig, trig, fill_last;
   logic [CHANNELS-1:0]   hit;

   assign arm_go    = (state_q == ST_IDLE) & arm & ~abort;
   assign run       = (state_q == ST_FILL) | (state_q == ST_WAIT) | (state_q == ST_POST);
   assign take      = strobe & ~abort;
   assign fill_last = PRE_NONE | (fill_cnt_q == PRE_LAST);

   la_prescaler #(.W(PRESC_W)) u_presc (
      .clk      (clk),
      .rst      (rst),
      .run_i    (run),
      .load_i   (arm_go),
      .pf_i     (prescaling_factor),
      .strobe_o (strobe)
   );

   // cur_q is still the previous sample here; probes is the sample being taken this strobe.
   always_comb begin
      free_run = 1'b1;
      hit      = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         hit[i] = kind_hit(kind_q[2*i +: 2], ~cur_q[i] & probes[i], cur_q[i] & ~probes[i]);
         if (kind_q[2*i +: 2] != TK_NONE) free_run = 1'b0;
      end
      edge_trig = have_prev_q & (free_run | (|hit));
   end

`ifdef CAPSEQ_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [TW-1:0] to_cnt_q;
   logic          trig_forced_q;

   assign force_trig = (to_cnt_q == TW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst || arm_go) begin
         to_cnt_q      <= '0;
         trig_forced_q <= 1'b0;
      end else if ((state_q == ST_WAIT) && take) begin
         if (trig) trig_forced_q <= ~edge_trig;
         else      to_cnt_q      <= to_cnt_q + TW'(1);
      end
   end

   assign trig_forced = trig_forced_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign force_trig     = 1'b0;
   assign trig_forced    = 1'b0;
`endif

   assign trig = edge_trig | force_trig;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (arm_go) state_d = ST_FILL;
         ST_FILL: if (strobe && fill_last) state_d = ST_WAIT;
         ST_WAIT: if (strobe && trig) state_d = ONE_POST ? ST_DONE : ST_POST;
         ST_POST: if (strobe && (post_cnt_q == POST_LAST)) state_d = ST_DONE;
         ST_DONE: if (dump_ack) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         kind_q      <= '0;
         cur_q       <= '0;
         have_prev_q <= 1'b0;
         addr_q      <= '0;
         fill_cnt_q  <= '0;
         post_cnt_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         trig_addr_q <= '0;
      end else begin
         state_q <= state_d;
         wr_en_q <= 1'b0;
         if (arm_go) begin
            kind_q      <= trigger_kind;
            cur_q       <= '0;
            have_prev_q <= 1'b0;
            addr_q      <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
         end else if (take) begin
            cur_q       <= probes;
            have_prev_q <= 1'b1;
            wr_en_q     <= 1'b1;
            wr_addr_q   <= addr_q;
            wr_data_q   <= probes;
            addr_q      <= addr_q + AW'(1);
            if (state_q == ST_FILL) fill_cnt_q <= fill_cnt_q + AW'(1);
            if ((state_q == ST_WAIT) && trig) begin
               trig_addr_q <= addr_q;
               post_cnt_q  <= (AW+1)'(1);
            end
            if (state_q == ST_POST) post_cnt_q <= post_cnt_q + (AW+1)'(1);
         end
      end
   end

   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign trig_addr    = trig_addr_q;
   assign busy         = (state_q != ST_IDLE);
   assign capture_done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed self-checking bench for capture_sequencer.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_capture_sequencer;
   import la_pkg::*;

   localparam int CH    = 16;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic            clk, rst;
   logic [28:0]     prescaling_factor;
   logic [2*CH-1:0] trigger_kind;
   logic [CH-1:0]   probes;
   logic            arm, abort, dump_ack;
   logic            wr_en, busy, capture_done, trig_forced;
   logic [AW-1:0]   wr_addr, trig_addr;
   logic [CH-1:0]   wr_data;

   int n_cmp, n_fail;

   capture_sequencer #(.CHANNELS(CH), .DEPTH(DEPTH), .PRETRIG(256)) dut (
      .clk(clk), .rst(rst), .prescaling_factor(prescaling_factor), .trigger_kind(trigger_kind),
      .probes(probes), .arm(arm), .abort(abort), .dump_ack(dump_ack),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .capture_done(capture_done), .trig_addr(trig_addr), .trig_forced(trig_forced)
   );

`ifdef CAPSEQ_TIMEOUT_EN
   logic            to_arm, to_abort, to_dump_ack;
   logic            t_wr_en, t_busy, t_done, t_forced;
   logic [AW-1:0]   t_wr_addr, t_trig_addr;
   logic [CH-1:0]   t_wr_data;

   capture_sequencer #(.CHANNELS(CH), .DEPTH(DEPTH), .PRETRIG(256), .TIMEOUT(10)) dut_to (
      .clk(clk), .rst(rst), .prescaling_factor(prescaling_factor), .trigger_kind(trigger_kind),
      .probes(probes), .arm(to_arm), .abort(to_abort), .dump_ack(to_dump_ack),
      .wr_en(t_wr_en), .wr_addr(t_wr_addr), .wr_data(t_wr_data), .busy(t_busy),
      .capture_done(t_done), .trig_addr(t_trig_addr), .trig_forced(t_forced)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Probe value presented for sample k; channels 12..15 toggle as noise (their kind is NONE).
   function automatic logic [CH-1:0] pval(input int mode, input int k);
      logic [CH-1:0] noise;
      noise = CH'((k & 15) << 12);
      case (mode)
         0:       pval = CH'(k * 37 + 5);
         1:       pval = noise | ((k >= 400) ? 16'h0008 : 16'h0000);
         2:       pval = noise | ((((k >= 10) && (k < 20)) || ((k >= 300) && (k < 350))) ? 16'h0001 : 16'h0000);
         3:       pval = noise | ((k >= 300) ? 16'h0020 : 16'h0000);
         default: pval = noise | ((k < 300) ? 16'h0020 : 16'h0000);
      endcase
   endfunction

   task automatic do_arm(input logic [28:0] pf, input logic [2*CH-1:0] kinds);
      prescaling_factor = pf;
      trigger_kind      = kinds;
      arm               = 1'b1;
      step(1);
      arm = 1'b0;
   endtask

   // Follows one acquisition from the arm edge; cyc counts edges after the arm edge.
   task automatic watch(input int first, input int spacing, input int mode, input int budget,
                        output int nwr, output int bad);
      int cyc;
      nwr = 0; bad = 0; cyc = 0;
      probes = pval(mode, 0);
      while (cyc < budget) begin
         step(1);
         cyc++;
         if (wr_en) begin
            if (cyc != first + spacing * nwr) bad++;
            if (wr_addr !== AW'(nwr % DEPTH)) bad++;
            if (wr_data !== pval(mode, nwr)) bad++;
            nwr++;
            probes = pval(mode, nwr);
         end
         if (capture_done) break;
      end
   endtask

   task automatic release_buf();
      dump_ack = 1'b1;
      step(1);
      dump_ack = 1'b0;
      n_cmp++; if (busy !== 1'b0 || capture_done !== 1'b0) begin n_fail++; $display("FAIL release: busy=%b done=%b want 0/0", busy, capture_done); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      n_cmp++; if (wr_en !== 1'b0)        begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
      n_cmp++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (capture_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", capture_done); end
      n_cmp++; if (wr_addr !== '0 || wr_data !== '0 || trig_addr !== '0 || trig_forced !== 1'b0) begin
         n_fail++; $display("FAIL rst_outputs: addr=%0d data=%h trig=%0d forced=%b want all 0", wr_addr, wr_data, trig_addr, trig_forced);
      end
   endtask

   task automatic test_free_run();
      int nwr, bad;
      do_arm(29'd4, '0);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL free_busy: got %b want 1", busy); end
      watch(4, 4, 0, 5000, nwr, bad);
      n_cmp++; if (bad !== 0)              begin n_fail++; $display("FAIL free_write_seq: %0d bad writes want 0", bad); end
      n_cmp++; if (nwr !== 1024)           begin n_fail++; $display("FAIL free_write_count: got %0d want 1024", nwr); end
      n_cmp++; if (capture_done !== 1'b1)  begin n_fail++; $display("FAIL free_done: got %b want 1", capture_done); end
      n_cmp++; if (trig_addr !== 10'd256)  begin n_fail++; $display("FAIL free_trig_addr: got %0d want 256", trig_addr); end
      n_cmp++; if (trig_forced !== 1'b0)   begin n_fail++; $display("FAIL free_forced: got %b want 0", trig_forced); end
      step(1);
      n_cmp++; if (wr_en !== 1'b0 || capture_done !== 1'b1) begin n_fail++; $display("FAIL free_after_done: wr_en=%b done=%b want 0/1", wr_en, capture_done); end
      release_buf();
   endtask

   task automatic test_rising_pf0();
      int nwr, bad;
      do_arm(29'd0, 32'h0000_0040);
      watch(1, 1, 1, 2000, nwr, bad);
      n_cmp++; if (bad !== 0)              begin n_fail++; $display("FAIL rise_write_seq: %0d bad writes want 0", bad); end
      n_cmp++; if (nwr !== 1168)           begin n_fail++; $display("FAIL rise_write_count: got %0d want 1168", nwr); end
      n_cmp++; if (trig_addr !== 10'd400)  begin n_fail++; $display("FAIL rise_trig_addr: got %0d want 400", trig_addr); end
      n_cmp++; if (wr_addr !== 10'd143)    begin n_fail++; $display("FAIL rise_last_addr: got %0d want 143", wr_addr); end
      n_cmp++; if (capture_done !== 1'b1)  begin n_fail++; $display("FAIL rise_done: got %b want 1", capture_done); end
      release_buf();
   endtask

   task automatic test_falling_pf_change();
      int nwr, bad;
      do_arm(29'd2, 32'h0000_0002);
      prescaling_factor = 29'd8;
      watch(2, 2, 2, 3000, nwr, bad);
      n_cmp++; if (bad !== 0)              begin n_fail++; $display("FAIL fall_write_seq: %0d bad writes want 0", bad); end
      n_cmp++; if (nwr !== 1118)           begin n_fail++; $display("FAIL fall_write_count: got %0d want 1118", nwr); end
      n_cmp++; if (trig_addr !== 10'd350)  begin n_fail++; $display("FAIL fall_trig_addr: got %0d want 350", trig_addr); end
      release_buf();
   endtask

   task automatic test_both();
      int nwr, bad;
      do_arm(29'd1, 32'h0000_0C00);
      watch(1, 1, 3, 2000, nwr, bad);
      n_cmp++; if (bad !== 0 || nwr !== 1068) begin n_fail++; $display("FAIL both_rise_writes: bad=%0d count=%0d want 0/1068", bad, nwr); end
      n_cmp++; if (trig_addr !== 10'd300)     begin n_fail++; $display("FAIL both_rise_trig: got %0d want 300", trig_addr); end
      release_buf();
      do_arm(29'd1, 32'h0000_0C00);
      watch(1, 1, 4, 2000, nwr, bad);
      n_cmp++; if (bad !== 0 || nwr !== 1068) begin n_fail++; $display("FAIL both_fall_writes: bad=%0d count=%0d want 0/1068", bad, nwr); end
      n_cmp++; if (trig_addr !== 10'd300)     begin n_fail++; $display("FAIL both_fall_trig: got %0d want 300", trig_addr); end
      release_buf();
   endtask

   task automatic test_abort();
      int seen;
      probes = '0;
      do_arm(29'd1, '0);
      step(300);
      n_cmp++; if (busy !== 1'b1 || wr_en !== 1'b1) begin n_fail++; $display("FAIL abort_pre: busy=%b wr_en=%b want 1/1", busy, wr_en); end
      n_cmp++; if (wr_addr !== 10'd299)             begin n_fail++; $display("FAIL abort_pre_addr: got %0d want 299", wr_addr); end
      dump_ack = 1'b1;
      step(1);
      dump_ack = 1'b0;
      n_cmp++; if (busy !== 1'b1 || wr_addr !== 10'd300) begin n_fail++; $display("FAIL dump_ack_ignored: busy=%b addr=%0d want 1/300", busy, wr_addr); end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      n_cmp++; if (busy !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL abort_post: busy=%b wr_en=%b want 0/0", busy, wr_en); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin step(1); if (wr_en !== 1'b0 || busy !== 1'b0) seen++; end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_quiet: %0d active cycles want 0", seen); end
      arm = 1'b1; abort = 1'b1;
      step(1);
      arm = 1'b0; abort = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin if (wr_en !== 1'b0 || busy !== 1'b0) seen++; step(1); end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL arm_abort_same: %0d active cycles want 0", seen); end
   endtask

   task automatic test_rearm();
      int nwr, bad;
      do_arm(29'd1, '0);
      watch(1, 1, 0, 1500, nwr, bad);
      n_cmp++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL rearm_first_done: got %b want 1", capture_done); end
      arm = 1'b1;
      step(1);
      arm = 1'b0;
      step(2);
      n_cmp++; if (capture_done !== 1'b1 || wr_en !== 1'b0) begin n_fail++; $display("FAIL arm_in_done: done=%b wr_en=%b want 1/0", capture_done, wr_en); end
      release_buf();
      do_arm(29'd1, '0);
      watch(1, 1, 0, 1500, nwr, bad);
      n_cmp++; if (bad !== 0 || nwr !== 1024) begin n_fail++; $display("FAIL rearm_writes: bad=%0d count=%0d want 0/1024", bad, nwr); end
      n_cmp++; if (trig_addr !== 10'd256 || capture_done !== 1'b1) begin n_fail++; $display("FAIL rearm_trig: addr=%0d done=%b want 256/1", trig_addr, capture_done); end
      release_buf();
   endtask

`ifdef CAPSEQ_TIMEOUT_EN
   task automatic test_timeout();
      int nwr;
      probes = '0;
      prescaling_factor = 29'd1;
      trigger_kind = 32'h0000_0001;
      to_arm = 1'b1;
      step(1);
      to_arm = 1'b0;
      nwr = 0;
      for (int i = 0; i < 2000; i++) begin
         step(1);
         if (t_wr_en) nwr++;
         if (t_done) break;
      end
      n_cmp++; if (t_done !== 1'b1)          begin n_fail++; $display("FAIL to_done: got %b want 1", t_done); end
      n_cmp++; if (nwr !== 1034)             begin n_fail++; $display("FAIL to_write_count: got %0d want 1034", nwr); end
      n_cmp++; if (t_trig_addr !== 10'd266)  begin n_fail++; $display("FAIL to_trig_addr: got %0d want 266", t_trig_addr); end
      n_cmp++; if (t_forced !== 1'b1)        begin n_fail++; $display("FAIL to_forced: got %b want 1", t_forced); end
      to_dump_ack = 1'b1;
      step(1);
      to_dump_ack = 1'b0;
      n_cmp++; if (t_busy !== 1'b0)          begin n_fail++; $display("FAIL to_release: busy=%b want 0", t_busy); end
   endtask
`endif

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; arm = 1'b0; abort = 1'b0; dump_ack = 1'b0;
      prescaling_factor = '0; trigger_kind = '0; probes = '0;
`ifdef CAPSEQ_TIMEOUT_EN
      to_arm = 1'b0; to_abort = 1'b0; to_dump_ack = 1'b0;
`endif
      test_reset();
      test_free_run();
      test_rising_pf0();
      test_falling_pf_change();
      test_both();
      test_abort();
      test_rearm();
`ifdef CAPSEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
